button_reader: RTL



---
 rtl/button_reader_pkg.sv | 19 +
 rtl/button_reader_sync.sv | 28 ++
 rtl/button_reader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/button_reader_pkg.sv
// Shared definitions for the button reader: FSM state encodings and the
// debounce counter width helper.
package button_reader_pkg;

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  // Bits needed to hold a count in 0..n; never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_reader_sync.sv
// Two-flop synchroniser for the raw button pin. The reset value is the
// pin's inactive level so that reset never looks like a press.
module button_reader_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  // Shift the asynchronous pin through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/button_reader.sv
// Push-button reader: synchroniser, debounce FSM and an 8-bit press counter.
// Produces a clean pressed level, one-cycle press/release pulses and a
// wrapping count of accepted presses. All outputs are registered.
module button_reader
  import button_reader_pkg::*;
#(
  parameter int   DEBOUNCE   = 250000,
  parameter logic ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       clear,
  output logic       pressed,
  output logic       press,
  output logic       release_pulse,
  output logic [7:0] press_count
);

  localparam int            CW       = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          s2;
  logic          act;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_d;
  logic          release_d;
  logic          pressed_d;

  button_reader_sync #(
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn),
    .q     (s2)
  );

  // Normalise polarity so act = 1 always means "pressed".
  assign act = s2 ^ ACTIVE_LOW;

  // State, debounce counter and registered outputs of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RELEASED;
      cnt_q         <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      pressed       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      press         <= press_d;
      release_pulse <= release_d;
      pressed       <= pressed_d;
    end
  end

  // Debounce decisions: a level change is accepted only after DEBOUNCE
  // consecutive agreeing samples; any disagreement falls back silently.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    pressed_d = pressed;
    unique case (state_q)
      S_RELEASED: begin
        if (act) begin
          state_d = S_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!act) begin
          state_d = S_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_PRESSED;
          press_d   = 1'b1;
          pressed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PRESSED: begin
        if (!act) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (act) begin
          state_d = S_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_RELEASED;
          release_d = 1'b1;
          pressed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Press counter: counts registered press pulses; clear wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_count <= 8'd0;
    end else if (clear) begin
      press_count <= 8'd0;
    end else if (press) begin
      press_count <= press_count + 8'd1;
    end
  end

endmodule
